// File: rtl/pdm_decoder.sv
`default_nettype none
// ============================================================================
// Module      : pdm_decoder
// Description : Second-order CIC decimator. It turns a 1-bit PDM stream into
//               signed PCM samples. When PDM_DECODER_SYNC_EN is defined, the
//               input first passes through a two-flop synchroniser.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_decoder #(
   parameter int DATA_BITS  = 12,
   parameter int DECIM_LOG2 = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pdm_in,
   output logic [DATA_BITS-1:0] dout,
   output logic                 dout_valid
);

   localparam int c_ACC_W = 2*DECIM_LOG2 + 1;
   localparam int c_SHIFT = 2*DECIM_LOG2 - DATA_BITS;
   localparam logic [c_ACC_W-1:0]        c_MID      = c_ACC_W'(1) << (2*DECIM_LOG2 - 1);
   localparam logic signed [c_ACC_W-1:0] c_POS_MAX  = c_ACC_W'((64'(1) << (DATA_BITS-1)) - 64'(1));
   localparam logic [DATA_BITS-1:0]      c_DOUT_MAX = {1'b0, {(DATA_BITS-1){1'b1}}};

   generate
      if (2*DECIM_LOG2 < DATA_BITS) begin : g_bad_params
         $error("pdm_decoder: 2*DECIM_LOG2 must be >= DATA_BITS");
      end
   endgenerate

   logic w_s_src;

`ifdef PDM_DECODER_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], pdm_in};
      end
   end

   assign w_s_src = sync_q[1];
`else
   assign w_s_src = pdm_in;
`endif

   logic                   s_q;
   logic [c_ACC_W-1:0]     i1_q, i1_d;
   logic [c_ACC_W-1:0]     i2_q, i2_d;
   logic [c_ACC_W-1:0]     d1_q, d1_d;
   logic [c_ACC_W-1:0]     d2_q, d2_d;
   logic [DECIM_LOG2-1:0]  cnt_q, cnt_d;
   logic [DATA_BITS-1:0]   dout_q, dout_d;
   logic                   dout_valid_q, dout_valid_d;

   logic                      w_dec;
   logic [c_ACC_W-1:0]        w_c1;
   logic [c_ACC_W-1:0]        w_c2;
   logic [c_ACC_W-1:0]        w_v;
   logic signed [c_ACC_W-1:0] w_shifted;
   logic [DATA_BITS-1:0]      w_scaled;

   // Integrators and combs use plain modular arithmetic. The differences stay
   // exact across wrap-around because the true c2 always fits in c_ACC_W bits.
   always_comb begin
      w_dec     = (cnt_q == '1);
      w_c1      = i2_q - d1_q;
      w_c2      = w_c1 - d2_q;
      w_v       = w_c2 - c_MID;
      w_shifted = $signed(w_v) >>> c_SHIFT;
      w_scaled  = (w_shifted > c_POS_MAX) ? c_DOUT_MAX : w_shifted[DATA_BITS-1:0];

      i1_d         = i1_q + {{(c_ACC_W-1){1'b0}}, s_q};
      i2_d         = i2_q + i1_q;
      cnt_d        = cnt_q + DECIM_LOG2'(1);
      d1_d         = d1_q;
      d2_d         = d2_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;

      if (w_dec) begin
         d1_d         = i2_q;
         d2_d         = w_c1;
         dout_d       = w_scaled;
         dout_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q          <= 1'b0;
         i1_q         <= '0;
         i2_q         <= '0;
         d1_q         <= '0;
         d2_q         <= '0;
         cnt_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         s_q          <= w_s_src;
         i1_q         <= i1_d;
         i2_q         <= i2_d;
         d1_q         <= d1_d;
         d2_q         <= d2_d;
         cnt_q        <= cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pdm_decoder.sv
`default_nettype none
// Bench for pdm_decoder. It runs R=64 and R=128 instances side by side against a
// double box-filter reference model built from the PDM input history.
module tb_pdm_decoder;

`ifdef PDM_DECODER_SYNC_EN
   localparam int P = 2;
`else
   localparam int P = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pdm_in;
   logic [11:0] dout_a, dout_b;
   logic        valid_a, valid_b;

   int checks   = 0;
   int failures = 0;
   int hist[$];
   int exp_dout[2];
   int nval[2];
   bit const_en;
   int const_val;

   always #5 clk = ~clk;

   pdm_decoder #(.DATA_BITS(12), .DECIM_LOG2(6)) u_dut_r64 (
      .clk(clk), .rst_n(rst_n), .pdm_in(pdm_in), .dout(dout_a), .dout_valid(valid_a)
   );

   pdm_decoder #(.DATA_BITS(12), .DECIM_LOG2(7)) u_dut_r128 (
      .clk(clk), .rst_n(rst_n), .pdm_in(pdm_in), .dout(dout_b), .dout_valid(valid_b)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // This is the PDM bit that was sampled on edge i. It is zero before reset release.
   function automatic int xs(input int i);
      if (i >= 1 && i < hist.size()) return hist[i];
      return 0;
   endfunction

   // c2 is two cascaded length-R box sums of the integrator input. The input
   // value entering edge j is the pdm bit that was sampled 1+P edges earlier.
   function automatic int cic(input int k, input int r);
      int acc;
      acc = 0;
      for (int m = k - r; m <= k - 1; m++)
         for (int j = m - r; j <= m - 1; j++)
            acc += xs(j - 1 - P);
      return acc;
   endfunction

   function automatic int scale(input int c2, input int lg);
      int v;
      int sh;
      v  = c2 - (1 << (2*lg - 1));
      sh = v >>> (2*lg - 12);
      if (sh > 2047) sh = 2047;
      return sh;
   endfunction

   function automatic int obs_dout(input int d);
      return (d == 0) ? int'($signed(dout_a)) : int'($signed(dout_b));
   endfunction

   function automatic int obs_valid(input int d);
      return (d == 0) ? int'(valid_a) : int'(valid_b);
   endfunction

   task automatic step(input bit b);
      int k;
      int lg;
      int r;
      bit ev;
      pdm_in = b;
      @(posedge clk);
      #1;
      hist.push_back(int'(b));
      k = hist.size() - 1;
      for (int d = 0; d < 2; d++) begin
         lg = 6 + d;
         r  = 1 << lg;
         ev = ((k % r) == 0);
         if (ev) begin
            exp_dout[d] = scale(cic(k, r), lg);
            nval[d]++;
         end
         chk((d == 0) ? "valid_r64 " : "valid_r128", obs_valid(d), int'(ev));
         chk((d == 0) ? "dout_r64 " : "dout_r128", obs_dout(d), exp_dout[d]);
         if (ev && const_en && nval[d] >= 4)
            chk((d == 0) ? "steady_r64 " : "steady_r128", obs_dout(d), const_val);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_dout_r64", obs_dout(0), 0);
      chk("rst_valid_r64", obs_valid(0), 0);
      chk("rst_dout_r128", obs_dout(1), 0);
      chk("rst_valid_r128", obs_valid(1), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hold_valid", obs_valid(0), 0);
      #1;
      rst_n = 1'b1;
      hist.delete();
      hist.push_back(0);
      exp_dout = '{0, 0};
      nval     = '{0, 0};
   endtask

   task automatic run_pattern(input int period, input int ones, input int cycles);
      for (int i = 0; i < cycles; i++) step((i % period) < ones);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dens;
      rst_n    = 1'b1;
      pdm_in   = 1'b0;
      const_en = 1'b0;
      #2;
      do_reset();

      const_en = 1'b1; const_val = 2047;
      run_pattern(1, 1, 12*64);
      const_en = 1'b0;
      repeat (20) step(1'b1);
      do_reset();

      const_en = 1'b1; const_val = -2048;
      run_pattern(1, 0, 9*64);
      do_reset();

      const_val = 0;
      run_pattern(2, 1, 9*64);
      do_reset();

      const_val = -1024;
      run_pattern(4, 1, 9*64);
      const_en = 1'b0;
      do_reset();

      repeat (100) step(1'b0);
      repeat (5*64) step(1'b1);

      for (int w = 0; w < 20; w++) begin
         dens = int'($urandom_range(0, 100));
         repeat (64) step(int'($urandom_range(0, 99)) < dens);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
